wb_regfile: RTL and testbench

- Consumer end of the MEM→WB pipeline interface.
- Takes the WB-stage control and data signals, selects the write-back result, and commits it into a 32 x 16-bit register file.
- Serves the two decode-stage read ports with write-through bypass.
- Exports the selected WB result for EX-stage forwarding, plus a saturating count of committed writes for debug and performance.

---
 rtl/wb_regfile_pkg.sv | 25 ++
 rtl/wb_regfile_array.sv | 60 ++++++
 rtl/wb_regfile.sv | 115 +++++++++++
 tb/tb_wb_regfile.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared sizing constants and helpers for the write-back register file.
// Imported by the storage array and the top-level wrapper.
package wb_regfile_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int          WCNT_W   = 16;
  localparam logic [15:0] WCNT_MAX = 16'hFFFF;

  // Saturating increment: once at the ceiling the value is held, never wrapped.
  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] value);
    logic [WCNT_W-1:0] next_v;
    if (value == WCNT_MAX) begin
      next_v = value;
    end else begin
      next_v = value + 16'd1;
    end
    return next_v;
  endfunction

endpackage

// File: rtl/wb_regfile_array.sv
// Architectural storage: one synchronous write port with async active-low clear
// and three asynchronous read ports. Location 0 has no storage and reads 0.
module wb_regfile_array
  import wb_regfile_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W,
  parameter int NR = NREGS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  input  logic [AW-1:0] raddr3,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] rdata3
);

  logic [DW-1:0] mem_r [1:NR-1];

  // Storage update: async clear of every location, otherwise a single write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NR; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (we && (waddr != {AW{1'b0}})) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Asynchronous reads; address 0 has no backing storage.
  always_comb begin
    rdata1 = {DW{1'b0}};
    rdata2 = {DW{1'b0}};
    rdata3 = {DW{1'b0}};
    if (raddr1 != {AW{1'b0}}) begin
      rdata1 = mem_r[raddr1];
    end else begin
      rdata1 = {DW{1'b0}};
    end
    if (raddr2 != {AW{1'b0}}) begin
      rdata2 = mem_r[raddr2];
    end else begin
      rdata2 = {DW{1'b0}};
    end
    if (raddr3 != {AW{1'b0}}) begin
      rdata3 = mem_r[raddr3];
    end else begin
      rdata3 = {DW{1'b0}};
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage consumer: selects the WB result, commits it to the register
// file, serves the decode read ports with write-first bypass, counts commits.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W,
  parameter int NREGS  = wb_regfile_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_REGWrite_W,
  input  logic              i_MEMtoReg_W,
  input  logic [ADDR_W-1:0] i_Write_Reg_W,
  input  logic [DATA_W-1:0] i_DMEM_out,
  input  logic [DATA_W-1:0] i_ALU_out,
  input  logic [ADDR_W-1:0] i_Read_Reg1_D,
  input  logic [ADDR_W-1:0] i_Read_Reg2_D,
  input  logic [ADDR_W-1:0] i_Dbg_Addr,
  output logic [DATA_W-1:0] o_Read_Data1_D,
  output logic [DATA_W-1:0] o_Read_Data2_D,
  output logic [DATA_W-1:0] o_Result_W,
  output logic [DATA_W-1:0] o_Dbg_Data,
  output logic [15:0]       o_Write_Count
);

  logic [DATA_W-1:0] result_s;
  logic              commit_s;
  logic [DATA_W-1:0] arr_rd1_s;
  logic [DATA_W-1:0] arr_rd2_s;
  logic [DATA_W-1:0] arr_dbg_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic [DATA_W-1:0] dbg_s;
  logic [WCNT_W-1:0] wcount_r;

  // Result select and commit qualification; writes to R0 are dropped here.
  always_comb begin
    result_s = {DATA_W{1'b0}};
    commit_s = 1'b0;
    if (i_MEMtoReg_W) begin
      result_s = i_DMEM_out;
    end else begin
      result_s = i_ALU_out;
    end
    if (i_REGWrite_W && (i_Write_Reg_W != REG_ZERO)) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  wb_regfile_array #(
    .DW (DATA_W),
    .AW (ADDR_W),
    .NR (NREGS)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (commit_s),
    .waddr  (i_Write_Reg_W),
    .wdata  (result_s),
    .raddr1 (i_Read_Reg1_D),
    .raddr2 (i_Read_Reg2_D),
    .raddr3 (i_Dbg_Addr),
    .rdata1 (arr_rd1_s),
    .rdata2 (arr_rd2_s),
    .rdata3 (arr_dbg_s)
  );

  // Decode read ports: R0 forced to zero, then same-cycle bypass of the WB value.
  // The bypass ignores rst so the decode stage sees the in-flight value during reset.
  always_comb begin
    rd1_s = {DATA_W{1'b0}};
    rd2_s = {DATA_W{1'b0}};
    dbg_s = {DATA_W{1'b0}};
    if (i_Read_Reg1_D == REG_ZERO) begin
      rd1_s = {DATA_W{1'b0}};
    end else if (i_REGWrite_W && (i_Write_Reg_W == i_Read_Reg1_D)) begin
      rd1_s = result_s;
    end else begin
      rd1_s = arr_rd1_s;
    end
    if (i_Read_Reg2_D == REG_ZERO) begin
      rd2_s = {DATA_W{1'b0}};
    end else if (i_REGWrite_W && (i_Write_Reg_W == i_Read_Reg2_D)) begin
      rd2_s = result_s;
    end else begin
      rd2_s = arr_rd2_s;
    end
    if (i_Dbg_Addr == REG_ZERO) begin
      dbg_s = {DATA_W{1'b0}};
    end else begin
      dbg_s = arr_dbg_s;
    end
  end

  // Committed-write counter, saturating at its ceiling until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcount_r <= {WCNT_W{1'b0}};
    end else if (commit_s) begin
      wcount_r <= sat_inc(wcount_r);
    end else begin
      wcount_r <= wcount_r;
    end
  end

  assign o_Result_W     = result_s;
  assign o_Read_Data1_D = rd1_s;
  assign o_Read_Data2_D = rd2_s;
  assign o_Dbg_Data     = dbg_s;
  assign o_Write_Count  = wcount_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        regwrite;
  logic        memtoreg;
  logic [4:0]  wreg;
  logic [15:0] dmem;
  logic [15:0] alu;
  logic [4:0]  rr1;
  logic [4:0]  rr2;
  logic [4:0]  dbga;
  logic [15:0] rd1;
  logic [15:0] rd2;
  logic [15:0] res;
  logic [15:0] dbg;
  logic [15:0] wcnt;

  logic [15:0] m_reg [32];
  int          m_cnt;
  int          n_checks;
  int          n_fail;

  wb_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .i_REGWrite_W   (regwrite),
    .i_MEMtoReg_W   (memtoreg),
    .i_Write_Reg_W  (wreg),
    .i_DMEM_out     (dmem),
    .i_ALU_out      (alu),
    .i_Read_Reg1_D  (rr1),
    .i_Read_Reg2_D  (rr2),
    .i_Dbg_Addr     (dbga),
    .o_Read_Data1_D (rd1),
    .o_Read_Data2_D (rd2),
    .o_Result_W     (res),
    .o_Dbg_Data     (dbg),
    .o_Write_Count  (wcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_result();
    return memtoreg ? dmem : alu;
  endfunction

  function automatic logic [15:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 16'h0000;
    if (regwrite && (wreg == a)) return m_result();
    return m_reg[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_reg[i] = 16'h0000;
    m_cnt = 0;
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [4:0] wa,
                       input logic [15:0] dm, input logic [15:0] al,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    regwrite = we; memtoreg = m2r; wreg = wa; dmem = dm; alu = al;
    rr1 = a1; rr2 = a2; dbga = ad;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".res"}, res, m_result());
    chk({tag, ".rd1"}, rd1, m_read(rr1));
    chk({tag, ".rd2"}, rd2, m_read(rr2));
    chk({tag, ".dbg"}, dbg, m_reg[dbga]);
    chk({tag, ".cnt"}, wcnt, 16'(m_cnt));
  endtask

  // One rising edge; the model commits what the spec says lands on that edge.
  task automatic clock_edge();
    @(posedge clk);
    if (rst && regwrite && (wreg != 5'd0)) begin
      m_reg[wreg] = m_result();
      if (m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_clear();
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 16'h0, 16'h0, 5'd0, 5'd0, 5'd0);
    #12 rst = 1'b1;

    // Reset state on all read ports.
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i); rr2 = 5'(31 - i); dbga = 5'(i);
      #1;
      chk("rst.rd1", rd1, 16'h0000);
      chk("rst.rd2", rd2, 16'h0000);
      chk("rst.dbg", dbg, 16'h0000);
    end
    chk("rst.cnt", wcnt, 16'h0000);
    @(posedge clk); #1;

    // ALU write with same-cycle bypass.
    drive(1'b1, 1'b0, 5'd5, 16'hBEEF, 16'h1234, 5'd5, 5'd0, 5'd5);
    #2;
    chk("alu.byp", rd1, 16'h1234);
    chk("alu.res", res, 16'h1234);
    chk("alu.dbg_pre", dbg, 16'h0000);
    clock_edge();
    drive(1'b0, 1'b0, 5'd0, 16'h0, 16'h0, 5'd0, 5'd0, 5'd5);
    #2;
    chk("alu.dbg", dbg, 16'h1234);
    chk("alu.cnt", wcnt, 16'h0001);

    // Memory write bypassed on both ports.
    drive(1'b1, 1'b1, 5'd5, 16'hBEEF, 16'h0000, 5'd5, 5'd5, 5'd0);
    #2;
    chk("mem.rd1", rd1, 16'hBEEF);
    chk("mem.rd2", rd2, 16'hBEEF);
    clock_edge();
    drive(1'b0, 1'b0, 5'd0, 16'h0, 16'h0, 5'd0, 5'd0, 5'd5);
    #2;
    chk("mem.dbg", dbg, 16'hBEEF);
    chk("mem.cnt", wcnt, 16'h0002);

    // Write to R0 is dropped.
    drive(1'b1, 1'b0, 5'd0, 16'h0, 16'hFFFF, 5'd0, 5'd0, 5'd0);
    #2;
    chk("r0.rd1", rd1, 16'h0000);
    clock_edge();
    #2;
    chk("r0.dbg", dbg, 16'h0000);
    chk("r0.cnt", wcnt, 16'h0002);
    check_all("r0.model");

    // Reset mid-cycle discards the in-flight write.
    drive(1'b1, 1'b0, 5'd7, 16'h0, 16'h00AA, 5'd0, 5'd0, 5'd7);
    clock_edge();
    drive(1'b1, 1'b0, 5'd7, 16'h0, 16'h5555, 5'd7, 5'd3, 5'd7);
    #2;
    chk("mid.pre", dbg, 16'h00AA);
    rst = 1'b0;
    m_clear();
    #1;
    chk("mid.dbg0", dbg, 16'h0000);
    chk("mid.byp", rd1, 16'h5555);
    chk("mid.rd2", rd2, 16'h0000);
    chk("mid.cnt0", wcnt, 16'h0000);
    clock_edge();
    chk("mid.dbg1", dbg, 16'h0000);
    chk("mid.cnt1", wcnt, 16'h0000);
    #2 rst = 1'b1;
    clock_edge();
    #2;
    chk("mid.dbg2", dbg, 16'h5555);
    chk("mid.cnt2", wcnt, 16'h0001);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom);
      drive(1'(($urandom % 4) != 0), 1'($urandom), wa, 16'($urandom), 16'($urandom),
            (($urandom % 3) == 0) ? wa : 5'($urandom),
            (($urandom % 3) == 0) ? wa : 5'($urandom),
            5'($urandom));
      #2;
      check_all("rand");
      clock_edge();
    end

    // Counter saturation.
    #2 rst = 1'b0;
    m_clear();
    #2 rst = 1'b1;
    for (int n = 0; n < 65534; n++) begin
      drive(1'b1, 1'b0, (n % 2 == 0) ? 5'd1 : 5'd2, 16'h0, 16'(n), 5'd0, 5'd0, 5'd0);
      clock_edge();
    end
    #2;
    chk("sat.fffe", wcnt, 16'hFFFE);
    drive(1'b1, 1'b1, 5'd3, 16'hA5A5, 16'h0, 5'd1, 5'd2, 5'd3);
    clock_edge();
    #2;
    chk("sat.ffff", wcnt, 16'hFFFF);
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 1'b0, 5'd4, 16'h0, 16'(16'h0100 + n), 5'd1, 5'd3, 5'd4);
      clock_edge();
    end
    #2;
    chk("sat.hold", wcnt, 16'hFFFF);
    check_all("sat.model");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
